// File: rtl/pif_xi_frontend_pkg.sv
// pif_xi_frontend_pkg: bus widths, register addresses and FSM encodings shared by the XI front end
package pif_xi_frontend_pkg;

    localparam int TXA           = 6;
    localparam int TXSUBA        = 1;
    localparam int I2C_DATA_BITS = 6;

    localparam logic [TXA:0] W_SCRATCH_REG = 7'h05;
    localparam logic [TXA:0] R_ID          = 7'h00;

    typedef enum logic [2:0] {
        PIFXI_IDLE  = 3'd0,
        PIFXI_WADDR = 3'd1,
        PIFXI_WDATA = 3'd2,
        PIFXI_RIDLE = 3'd3,
        PIFXI_RWAIT = 3'd4,
        PIFXI_RSEND = 3'd5
    } pifxi_state_e;

    function automatic int cnt_width(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/pif_xi_frontend.sv
// pif_xi_frontend: I2C byte stream to XI register-bus strobes; optional PIF_XI_WR_AUTOINC_EN walks the pointer on writes
module pif_xi_frontend
    import pif_xi_frontend_pkg::*;
#(
    parameter int READ_LAT = 2
) (
    input  logic                     xclk,
    input  logic                     sys_rst,
    input  logic                     i2c_start,
    input  logic                     i2c_rnw,
    input  logic                     i2c_stop,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_data,
    input  logic                     tx_req,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic [7:0]               XO,
    output logic                     XI_PWr,
    output logic [TXA:0]             XI_PRWA,
    output logic [I2C_DATA_BITS-1:0] XI_PD,
    output logic [TXSUBA:0]          XI_PRdSubA,
    output logic                     XI_PRdFinished,
    output logic                     busy
);

    localparam int CW = cnt_width(READ_LAT);

    pifxi_state_e             state_q, state_d;
    logic [TXA:0]             prwa_q, prwa_d;
    logic [I2C_DATA_BITS-1:0] pd_q, pd_d;
    logic [TXSUBA:0]          suba_q, suba_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [7:0]               txd_q, txd_d;
    logic                     txv_q, txv_d;
    logic                     pwr_q, pwr_d;
    logic                     fin_q, fin_d;

    // next-state and registered-output computation; start/stop override the per-state transition
    always_comb begin
        state_d = state_q;
        prwa_d  = prwa_q;
        pd_d    = pd_q;
        suba_d  = suba_q;
        cnt_d   = cnt_q;
        txd_d   = txd_q;
        txv_d   = 1'b0;
        pwr_d   = 1'b0;
        fin_d   = 1'b0;
`ifdef PIF_XI_WR_AUTOINC_EN
        if (pwr_q) prwa_d = prwa_q + 1'b1;
`else
`endif
        case (state_q)
            PIFXI_WADDR: begin
                if (rx_valid) begin
                    prwa_d  = rx_data[TXA:0];
                    state_d = PIFXI_WDATA;
                end
            end
            PIFXI_WDATA: begin
                if (rx_valid) begin
                    pd_d  = rx_data[I2C_DATA_BITS-1:0];
                    pwr_d = 1'b1;
                end
            end
            PIFXI_RIDLE: begin
                if (tx_req) begin
                    cnt_d   = CW'(READ_LAT - 1);
                    state_d = PIFXI_RWAIT;
                end
            end
            PIFXI_RWAIT: begin
                if (cnt_q == '0) state_d = PIFXI_RSEND;
                else cnt_d = cnt_q - 1'b1;
            end
            PIFXI_RSEND: begin
                txd_d   = XO;
                txv_d   = 1'b1;
                fin_d   = 1'b1;
                suba_d  = suba_q + 1'b1;
                state_d = PIFXI_RIDLE;
            end
            default: ;
        endcase
        if (i2c_stop) state_d = PIFXI_IDLE;
        if (i2c_start) begin
            state_d = i2c_rnw ? PIFXI_RIDLE : PIFXI_WADDR;
            suba_d  = i2c_rnw ? '0 : suba_d;
        end
    end

    // state and output registers with synchronous reset
    always_ff @(posedge xclk) begin
        if (sys_rst) begin
            state_q <= PIFXI_IDLE;
            prwa_q  <= '0;
            pd_q    <= '0;
            suba_q  <= '0;
            cnt_q   <= '0;
            txd_q   <= '0;
            txv_q   <= 1'b0;
            pwr_q   <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            prwa_q  <= prwa_d;
            pd_q    <= pd_d;
            suba_q  <= suba_d;
            cnt_q   <= cnt_d;
            txd_q   <= txd_d;
            txv_q   <= txv_d;
            pwr_q   <= pwr_d;
            fin_q   <= fin_d;
        end
    end

    assign tx_data        = txd_q;
    assign tx_valid       = txv_q;
    assign XI_PWr         = pwr_q;
    assign XI_PRWA        = prwa_q;
    assign XI_PD          = pd_q;
    assign XI_PRdSubA     = suba_q;
    assign XI_PRdFinished = fin_q;
    assign busy           = (state_q != PIFXI_IDLE);

endmodule
